// File: rtl/sap_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap_controller_sequencer
//
// Control unit for the 8-bit SAP-class CPU. A six-state one-hot ring counter
// (T1..T6) sequences a three-state fetch followed by a three-state execute.
// In every state the ring, the halt flag, the opcode and clear are decoded
// combinationally into the 12-bit control word.
//
// Ports:
//   clk      in   system clock, rising edge
//   clear    in   synchronous active-high reset; also forces a NOP control word
//   run      in   1 = advance one T-state per clock, 0 = hold
//   opcode   in   [3:0] instruction register opcode, valid from T4 onward
//   t_state  out  [5:0] one-hot ring, bit0 = T1 ... bit5 = T6
//   cp, ep   out  PC increment / PC onto bus (active high)
//   n_lm     out  MAR load (active low)
//   n_ce     out  RAM onto bus (active low)
//   n_li     out  IR load (active low)
//   n_ei     out  IR address nibble onto bus (active low)
//   n_la     out  A load (active low)
//   ea       out  A onto bus (active high)
//   su, eu   out  ALU subtract select / ALU onto bus (active high)
//   n_lb     out  B load (active low)
//   n_lo     out  output register load (active low)
//   hlt      out  halted flag
//
// state | meaning
// ------+--------------------------------------------------------------
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, load IR
// T4    | execute 1: address nibble -> MAR (LDA/ADD/SUB), A -> OUT (OUT),
//       |            HLT latches the halt flag and freezes the ring here
// T5    | execute 2: RAM -> A (LDA) or RAM -> B (ADD/SUB)
// T6    | execute 3: ALU -> A (ADD/SUB)
// -----------------------------------------------------------------------------
module sap_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       n_lm,
    output logic       n_ce,
    output logic       n_li,
    output logic       n_ei,
    output logic       n_la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       n_lb,
    output logic       n_lo,
    output logic       hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    ring_t ring;
    logic  hlt_q;

    // clear beats everything; once halted the ring is frozen until clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            ring  <= T1;
            hlt_q <= 1'b0;
        end else if (run && !hlt_q) begin
            if (ring == T4 && opcode == OP_HLT) begin
                hlt_q <= 1'b1;
            end else begin
                case (ring)
                    T1:      ring <= T2;
                    T2:      ring <= T3;
                    T3:      ring <= T4;
                    T4:      ring <= T5;
                    T5:      ring <= T6;
                    default: ring <= T1;
                endcase
            end
        end
    end

    assign t_state = ring;
    assign hlt     = hlt_q;

    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        n_lm = 1'b1;
        n_ce = 1'b1;
        n_li = 1'b1;
        n_ei = 1'b1;
        n_la = 1'b1;
        ea   = 1'b0;
        su   = 1'b0;
        eu   = 1'b0;
        n_lb = 1'b1;
        n_lo = 1'b1;
        if (!clear && !hlt_q) begin
            case (ring)
                T1: begin
                    ep   = 1'b1;
                    n_lm = 1'b0;
                end
                T2: cp = 1'b1;
                T3: begin
                    n_ce = 1'b0;
                    n_li = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            n_lm = 1'b0;
                            n_ei = 1'b0;
                        end
                        OP_OUT: begin
                            ea   = 1'b1;
                            n_lo = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            n_ce = 1'b0;
                            n_la = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            n_ce = 1'b0;
                            n_lb = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin
                            eu   = 1'b1;
                            n_la = 1'b0;
                        end
                        OP_SUB: begin
                            eu   = 1'b1;
                            n_la = 1'b0;
                            su   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
module tb_sap_controller_sequencer;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [5:0] t_state;
    logic       cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo, hlt;

    int checks = 0;
    int failures = 0;

    // Reference model: instruction step 0..5 and a halted flag.
    int m_step = 0;
    bit m_halted = 1'b0;
    bit m_known = 1'b0;

    sap_controller_sequencer dut (
        .clk     (clk),
        .clear   (clear),
        .run     (run),
        .opcode  (opcode),
        .t_state (t_state),
        .cp      (cp),
        .ep      (ep),
        .n_lm    (n_lm),
        .n_ce    (n_ce),
        .n_li    (n_li),
        .n_ei    (n_ei),
        .n_la    (n_la),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .n_lb    (n_lb),
        .n_lo    (n_lo),
        .hlt     (hlt)
    );

    always #5 clk = ~clk;

    // Control word packing: {cp,ep,n_lm,n_ce,n_li,n_ei,n_la,ea,su,eu,n_lb,n_lo}
    function automatic logic [11:0] exp_cw(input int st, input logic [3:0] op,
                                           input bit clr, input bit halted);
        logic c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo;
        c_cp = 0; c_ep = 0; c_lm = 1; c_ce = 1; c_li = 1; c_ei = 1;
        c_la = 1; c_ea = 0; c_su = 0; c_eu = 0; c_lb = 1; c_lo = 1;
        if (!clr && !halted) begin
            if (st == 0) begin c_ep = 1; c_lm = 0; end
            if (st == 1) c_cp = 1;
            if (st == 2) begin c_ce = 0; c_li = 0; end
            if (op == 4'h0) begin
                if (st == 3) begin c_lm = 0; c_ei = 0; end
                if (st == 4) begin c_ce = 0; c_la = 0; end
            end
            if (op == 4'h1 || op == 4'h2) begin
                if (st == 3) begin c_lm = 0; c_ei = 0; end
                if (st == 4) begin c_ce = 0; c_lb = 0; end
                if (st == 5) begin c_eu = 1; c_la = 0; c_su = (op == 4'h2); end
            end
            if (op == 4'hE && st == 3) begin c_ea = 1; c_lo = 0; end
        end
        return {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo};
    endfunction

    task automatic step(input bit r, input bit c, input logic [3:0] op);
        logic [11:0] obs, exp;
        logic [5:0] exp_t;
        @(negedge clk);
        run = r;
        clear = c;
        opcode = op;
        #1;
        obs = {cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo};
        exp = exp_cw(m_step, op, c, m_halted);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL cw step=%0d op=%h clr=%0d obs=%h exp=%h", m_step, op, c, obs, exp);
        end
        if (m_known) begin
            exp_t = 6'(1 << m_step);
            checks++;
            assert (t_state === exp_t) else begin
                failures++;
                $error("FAIL t_state obs=%b exp=%b", t_state, exp_t);
            end
            checks++;
            assert (hlt === m_halted) else begin
                failures++;
                $error("FAIL hlt obs=%b exp=%b", hlt, m_halted);
            end
        end
        @(posedge clk);
        if (c) begin
            m_step = 0;
            m_halted = 0;
            m_known = 1;
        end else if (r && !m_halted) begin
            if (m_step == 3 && op == 4'hF) m_halted = 1;
            else m_step = (m_step + 1) % 6;
        end
    endtask

    task automatic instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) step(1, 0, op);
    endtask

    logic [3:0] rop;
    logic [3:0] op_pool [6];

    initial begin
        op_pool[0] = 4'h0; op_pool[1] = 4'h1; op_pool[2] = 4'h2;
        op_pool[3] = 4'hE; op_pool[4] = 4'hF; op_pool[5] = 4'h7;

        // Reset, then a paused cycle shows the T1 reset state.
        step(1, 1, 4'h0);
        step(0, 0, 4'h0);

        instr(4'h0);
        instr(4'h1);
        instr(4'h2);
        instr(4'hE);

        // Pause at T3 for five clocks, then resume.
        step(1, 0, 4'h0);
        step(1, 0, 4'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 4'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 4'h0);

        // HLT at T4 freezes the ring until clear.
        for (int i = 0; i < 4; i++) step(1, 0, 4'hF);
        for (int i = 0; i < 12; i++) step(1, 0, 4'hF);
        for (int i = 0; i < 4; i++) step(i[0], 0, op_pool[i]);
        step(1, 1, 4'hF);
        step(0, 0, 4'h0);

        // Clear in T5 of LDA abandons it; undefined opcode runs all-NOP execute.
        for (int i = 0; i < 4; i++) step(1, 0, 4'h0);
        step(1, 1, 4'h0);
        instr(4'h7);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rop = 4'($urandom_range(0, 15));
            else rop = op_pool[$urandom_range(0, 5)];
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), rop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
